// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Two writeback requesters share the single register file write port
// (WE3/A3/WD3). Each requester pushes {addr, data} into its own 2-entry FIFO
// through a valid/ready handshake. A round-robin arbiter pops at most one FIFO
// head per cycle into a registered write port that drives the register file
// directly.
//
// Ports:
//   clk, rst_n                clock and asynchronous active-low reset
//   reqN_valid/addr/data      requester N write offer (N = 0, 1)
//   reqN_ready                FIFO N has room; depends only on registered count
//   WE3, A3, WD3              registered register file write port
//   idle                      both FIFOs empty and no write on the port
//
// Optional feature macro: RF_X0_FILTER_EN
//   When defined, a granted entry addressed to x0 is popped and uses its grant
//   slot, but WE3 is held low for it. A3/WD3 still load the entry.
//
// Arbiter state (last):
//   last | meaning
//   0    | FIFO 0 granted most recently; FIFO 1 wins the next tie
//   1    | FIFO 1 granted most recently; FIFO 0 wins the next tie (reset)

module rf_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [4:0]       req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             WE3,
    output logic [4:0]       A3,
    output logic [WIDTH-1:0] WD3,
    output logic             idle
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [4:0]       fifo_addr [2][2];
    logic [WIDTH-1:0] fifo_data [2][2];
    logic [1:0]       count [2];
    logic [1:0]       wptr;
    logic [1:0]       rptr;
    logic             last;

    logic [1:0]       in_valid;
    logic [4:0]       in_addr [2];
    logic [WIDTH-1:0] in_data [2];
    logic [1:0]       ready;
    logic [1:0]       push;
    logic [1:0]       nonempty;
    logic [1:0]       pop;
    logic             gnt_valid;
    logic             gnt_idx;
    logic [4:0]       head_addr;
    logic [WIDTH-1:0] head_data;
    logic             issue_we;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    assign ready[0]    = (count[0] != FULL_COUNT);
    assign ready[1]    = (count[1] != FULL_COUNT);
    assign push        = in_valid & ready;
    assign nonempty[0] = (count[0] != 2'd0);
    assign nonempty[1] = (count[1] != 2'd0);

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_comb begin
        gnt_valid = nonempty[0] | nonempty[1];
        // On a tie the FIFO not granted last wins; otherwise take whichever
        // FIFO holds data (the index is don't-care when both are empty).
        if (nonempty[0] && nonempty[1]) begin
            gnt_idx = ~last;
        end else begin
            gnt_idx = ~nonempty[0];
        end
        pop = 2'b00;
        if (gnt_valid) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    assign head_addr = fifo_addr[gnt_idx][rptr[gnt_idx]];
    assign head_data = fifo_data[gnt_idx][rptr[gnt_idx]];

`ifdef RF_X0_FILTER_EN
    assign issue_we = (head_addr != 5'd0);
`else
    assign issue_we = 1'b1;
`endif

    // Entry storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                fifo_addr[i][wptr[i]] <= in_addr[i];
                fifo_data[i][wptr[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                count[i] <= 2'd0;
            end
            wptr <= 2'b00;
            rptr <= 2'b00;
            last <= 1'b1;
            WE3  <= 1'b0;
            A3   <= 5'd0;
            WD3  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                count[i] <= count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
                if (push[i]) begin
                    wptr[i] <= ~wptr[i];
                end
                if (pop[i]) begin
                    rptr[i] <= ~rptr[i];
                end
            end
            if (gnt_valid) begin
                last <= gnt_idx;
                WE3  <= issue_we;
                A3   <= head_addr;
                WD3  <= head_data;
            end else begin
                WE3  <= 1'b0;
            end
        end
    end

    assign idle = (count[0] == 2'd0) && (count[1] == 2'd0) && !WE3;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = 5'd0;
    logic [31:0] req0_data = 32'd0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = 5'd0;
    logic [31:0] req1_data = 32'd0;
    logic        req1_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        idle;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rf [32];
    logic [4:0]  q0a [$];
    logic [31:0] q0d [$];
    logic [4:0]  q1a [$];
    logic [31:0] q1d [$];
    logic [4:0]  wr_a [$];
    logic [31:0] wr_d [$];

    rf_write_arbiter #(.WIDTH(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Register file model fed by the write port.
    always @(posedge clk) begin
        if (WE3 === 1'b1) rf[A3] <= WD3;
    end

    // One cycle at the falling edge: log the write port, then present the
    // head of each stimulus queue. Ready is registered, so the value seen
    // here decides whether the offer is taken at the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (WE3 === 1'b1) begin
            wr_a.push_back(A3);
            wr_d.push_back(WD3);
        end
        if (q0a.size() > 0) begin
            req0_valid = 1'b1; req0_addr = q0a[0]; req0_data = q0d[0];
            if (req0_ready === 1'b1) begin
                void'(q0a.pop_front()); void'(q0d.pop_front());
            end
        end else begin
            req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
        end
        if (q1a.size() > 0) begin
            req1_valid = 1'b1; req1_addr = q1a[0]; req1_data = q1d[0];
            if (req1_ready === 1'b1) begin
                void'(q1a.pop_front()); void'(q1d.pop_front());
            end
        end else begin
            req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        q0a.delete(); q0d.delete(); q1a.delete(); q1d.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_a.delete(); wr_d.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL reset_ready0 got %b exp 1", req0_ready); else n_pass++;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL reset_ready1 got %b exp 1", req1_ready); else n_pass++;
        n_checks++; if (WE3 !== 1'b0) $display("FAIL reset_we3 got %b exp 0", WE3); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle); else n_pass++;
        n_checks++; if (A3 !== 5'd0 || WD3 !== 32'd0) $display("FAIL reset_a3_wd3 got %0d/%h exp 0/0", A3, WD3); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        q0a.push_back(5'd5); q0d.push_back(32'hDEADBEEF);
        tick();                       // offer, accepted at edge E
        tick();                       // after E
        n_checks++; if (WE3 !== 1'b0) $display("FAIL single_we3_early got %b exp 0", WE3); else n_pass++;
        n_checks++; if (idle !== 1'b0) $display("FAIL single_busy got %b exp 0", idle); else n_pass++;
        tick();                       // after E+1
        n_checks++; if (WE3 !== 1'b1) $display("FAIL single_we3 got %b exp 1", WE3); else n_pass++;
        n_checks++; if (A3 !== 5'd5) $display("FAIL single_a3 got %0d exp 5", A3); else n_pass++;
        n_checks++; if (WD3 !== 32'hDEADBEEF) $display("FAIL single_wd3 got %h exp deadbeef", WD3); else n_pass++;
        tick();                       // after E+2
        n_checks++; if (rf[5] !== 32'hDEADBEEF) $display("FAIL single_rf5 got %h exp deadbeef", rf[5]); else n_pass++;
        n_checks++; if (WE3 !== 1'b0) $display("FAIL single_we3_off got %b exp 0", WE3); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL single_idle got %b exp 1", idle); else n_pass++;
    endtask

    task automatic test_contention();
        logic [4:0]  exp_a [6];
        logic [31:0] exp_d [6];
        exp_a = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
        exp_d = '{32'h10, 32'h40, 32'h20, 32'h50, 32'h30, 32'h60};
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            q0a.push_back(5'(i));     q0d.push_back(32'(i * 16));
            q1a.push_back(5'(i + 3)); q1d.push_back(32'((i + 3) * 16));
        end
        for (int k = 0; k < 40 && wr_a.size() < 6; k++) tick();
        n_checks++;
        if (wr_a.size() != 6) $display("FAIL contention_count got %0d exp 6", wr_a.size());
        else begin
            n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (wr_a[i] !== exp_a[i]) $display("FAIL contention_a3[%0d] got %0d exp %0d", i, wr_a[i], exp_a[i]); else n_pass++;
                n_checks++; if (wr_d[i] !== exp_d[i]) $display("FAIL contention_wd3[%0d] got %h exp %h", i, wr_d[i], exp_d[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [4:0]  r1_a [$];
        logic [31:0] r1_d [$];
        logic [4:0]  r0_a [$];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0a.push_back(5'(11 + i)); q0d.push_back(32'(32'h11 + i));
        end
        for (int i = 0; i < 3; i++) begin
            q1a.push_back(5'(8 + i)); q1d.push_back(32'(32'h108 + i));
        end
        tick(); tick(); tick();       // FIFO 1 holds two entries, none drained yet
        n_checks++; if (req1_ready !== 1'b0) $display("FAIL bp_ready1_full got %b exp 0", req1_ready); else n_pass++;
        n_checks++; if (q1a.size() != 1) $display("FAIL bp_third_pending got %0d exp 1", q1a.size()); else n_pass++;
        tick();                       // FIFO 1 drained once, FIFO 0 now full
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL bp_ready1_back got %b exp 1", req1_ready); else n_pass++;
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL bp_ready0_full got %b exp 0", req0_ready); else n_pass++;
        for (int k = 0; k < 50 && wr_a.size() < 7; k++) tick();
        n_checks++;
        if (wr_a.size() != 7) $display("FAIL bp_count got %0d exp 7", wr_a.size());
        else begin
            n_pass++;
            for (int i = 0; i < 7; i++) begin
                if (wr_a[i] < 5'd11) begin r1_a.push_back(wr_a[i]); r1_d.push_back(wr_d[i]); end
                else r0_a.push_back(wr_a[i]);
            end
            n_checks++;
            if (r1_a.size() != 3) $display("FAIL bp_req1_writes got %0d exp 3", r1_a.size());
            else begin
                n_pass++;
                for (int i = 0; i < 3; i++) begin
                    n_checks++;
                    if (r1_a[i] !== 5'(8 + i) || r1_d[i] !== 32'(32'h108 + i))
                        $display("FAIL bp_req1_order[%0d] got %0d/%h exp %0d/%h", i, r1_a[i], r1_d[i], 8 + i, 32'h108 + i);
                    else n_pass++;
                end
            end
            n_checks++;
            if (r0_a.size() != 4 || r0_a[0] !== 5'd11 || r0_a[3] !== 5'd14)
                $display("FAIL bp_req0_order got %0d entries", r0_a.size());
            else n_pass++;
        end
    endtask

    task automatic test_same_reg();
        do_reset();
        q0a.push_back(5'd7); q0d.push_back(32'hA);
        tick();
        q1a.push_back(5'd7); q1d.push_back(32'hB);
        repeat (6) tick();
        n_checks++; if (rf[7] !== 32'hB) $display("FAIL same_reg_rf7 got %h exp b", rf[7]); else n_pass++;
        n_checks++;
        if (wr_d.size() != 2 || wr_d[0] !== 32'hA || wr_d[1] !== 32'hB)
            $display("FAIL same_reg_order got %0d writes", wr_d.size());
        else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        q0a.push_back(5'd0); q0d.push_back(32'hFFFF);
        q0a.push_back(5'd3); q0d.push_back(32'h33);
        tick(); tick(); tick();       // x0 pops at E2, entry 3 pops at E3
`ifdef RF_X0_FILTER_EN
        n_checks++;
        if (wr_a.size() != 0) $display("FAIL x0_filtered got %0d writes exp 0", wr_a.size()); else n_pass++;
`else
        n_checks++;
        if (wr_a.size() != 1 || wr_a[0] !== 5'd0 || wr_d[0] !== 32'hFFFF)
            $display("FAIL x0_issued got %0d writes exp 1 to x0", wr_a.size());
        else n_pass++;
`endif
        tick();
        n_checks++; if (WE3 !== 1'b1 || A3 !== 5'd3) $display("FAIL x0_next got we %b a3 %0d exp 1/3", WE3, A3); else n_pass++;
        tick();
        n_checks++; if (idle !== 1'b1) $display("FAIL x0_idle got %b exp 1", idle); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0a.push_back(5'(20 + i)); q0d.push_back(32'(i));
            q1a.push_back(5'(24 + i)); q1d.push_back(32'(i));
        end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (WE3 !== 1'b0) $display("FAIL mid_rst_we3 got %b exp 0", WE3); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL mid_rst_idle got %b exp 1", idle); else n_pass++;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) $display("FAIL mid_rst_ready got %b%b exp 11", req1_ready, req0_ready); else n_pass++;
        q0a.delete(); q0d.delete(); q1a.delete(); q1d.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_a.delete(); wr_d.delete();
        repeat (6) tick();
        n_checks++; if (wr_a.size() != 0) $display("FAIL mid_rst_no_writes got %0d exp 0", wr_a.size()); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL mid_rst_idle_after got %b exp 1", idle); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_same_reg();
        test_x0();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
